// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU.
package serial_alu_pkg;

  // Opcode encoding as seen on the op port.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Single-bit ALU slice: one result bit and one carry per call.
// SUB inverts b here so the top only has to seed the carry with 1.
module alu_bit_slice
  import serial_alu_pkg::*;
(
  input  logic    a,
  input  logic    b,
  input  logic    cin,
  input  alu_op_t op,
  output logic    r,
  output logic    co
);

  logic b_eff;

  // Evaluate the selected operation for this bit position.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    r     = 1'b0;
    co    = 1'b0;
    b_eff = (op == OP_SUB) ? ~b : b;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: begin
        r  = a ^ b_eff ^ cin;
        co = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: accepts an operand pair, evaluates LSB first through
// one bit slice over WIDTH cycles, then presents result and flags.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  alu_state_t       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr;
  alu_op_t          op_q;
  logic             carry;
  logic             slice_r, slice_co;
  logic             accept, last_bit;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign last_bit = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

  alu_bit_slice u_slice (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .cin(carry),
    .op (op_q),
    .r  (slice_r),
    .co (slice_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake decode from registered state only.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CW'(WIDTH - 1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand shift registers, opcode and running carry.
  always_ff @(posedge clk) begin
    // NOTE: these are always loaded on accept before use, so they carry no reset.
    if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      op_q  <= alu_op_t'(op);
      carry <= (alu_op_t'(op) == OP_SUB) | ((alu_op_t'(op) == OP_ADD) & cin);
    end else if (state == ST_RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      carry <= slice_co;
    end
  end

  // Bit counter, result shift-in and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == ST_RUN) begin
      result <= {slice_r, result[WIDTH-1:1]};
      if (!last_bit) cnt <= cnt + CW'(1);
      if (last_bit) begin
        cout <= slice_co;
        // carry still holds the carry into the MSB during the last cycle
        ovf  <= carry ^ slice_co;
      end
    end
  end

  assign zero = (result == '0);

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8): vector table plus
// backpressure and mid-run reset sequences.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout, zero, ovf;

  int checks = 0;
  int errors = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .cout     (cout),
    .zero     (zero),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_result;
    logic         exp_cout;
    logic         exp_ovf;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait for out_valid; leaves the DUT in DONE.
  task automatic start_and_wait(input logic [1:0] o, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input logic vc,
                                output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    op = o; a = va; b = vb; cin = vc; in_valid = 1'b1;
    lat = 0;
    while (lat < 40) begin
      tick();
      lat++;
      in_valid = 1'b0;
      if (out_valid) break;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("in_ready_after_release", in_ready, 1'b1);
    check("out_valid_after_release", out_valid, 1'b0);
  endtask

  initial begin
    int lat;
    string tag;

    vecs[0]  = '{OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_ADD, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{OP_SUB, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{OP_AND, 8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_OR,  8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{OP_SUB, 8'h3C, 8'hF0, 1'b0, 8'h4C, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[10] = '{OP_SUB, 8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{OP_AND, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

    // Reset with in_valid asserted: the request must be ignored.
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 8'hAA; b = 8'h55; cin = 1'b1; op = OP_ADD;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 8'h00);
    check("reset_cout", cout, 1'b0);
    check("reset_ovf", ovf, 1'b0);
    check("reset_zero", zero, 1'b1);

    // Table-driven operations.
    for (int i = 0; i < 12; i++) begin
      start_and_wait(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
      tag = $sformatf("v%0d", i);
      check({tag, "_latency"}, lat, 9);
      check({tag, "_result"}, result, vecs[i].exp_result);
      check({tag, "_cout"}, cout, vecs[i].exp_cout);
      check({tag, "_ovf"}, ovf, vecs[i].exp_ovf);
      check({tag, "_zero"}, zero, vecs[i].exp_zero);
      release_result();
    end

    // Backpressure: DONE holds while new operands are offered.
    start_and_wait(OP_ADD, 8'h7F, 8'h01, 1'b0, lat);
    check("bp_latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      a = 8'h11; b = 8'h22; op = OP_SUB; cin = 1'b1;
      in_valid = (k % 2) == 0;
      tick();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_result", result, 8'h80);
      check("bp_ovf", ovf, 1'b1);
      check("bp_cout", cout, 1'b0);
    end
    in_valid = 1'b0;
    release_result();
    check("bp_result_after_release", result, 8'h80);
    tick();
    check("bp_no_capture_in_ready", in_ready, 1'b1);

    // Reset during the 4th RUN cycle of an ADD.
    op = OP_ADD; a = 8'hFF; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("midrun_busy", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_out_valid", out_valid, 1'b0);
    check("midrun_result", result, 8'h00);
    check("midrun_in_ready", in_ready, 1'b1);
    check("midrun_cout", cout, 1'b0);
    start_and_wait(OP_ADD, 8'h12, 8'h34, 1'b0, lat);
    check("post_reset_latency", lat, 9);
    check("post_reset_result", result, 8'h46);
    check("post_reset_cout", cout, 1'b0);
    release_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial, parametrised-width ALU. It accepts one operand pair and opcode through a valid/ready handshake, then evaluates AND, OR, ADD or SUB one bit per clock, LSB first, through a single-bit slice. It returns a WIDTH-bit result with carry, zero and signed-overflow flags through a second valid/ready handshake. It is the area-minimal arithmetic unit for control-path datapaths where latency is cheap and gates are not.

## Interface
- `WIDTH`, default 8: operand/result width; legal range 2..64.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: operands/opcode valid.
- `in_ready` out 1: unit idle, can accept.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in. Used by ADD only; ignored otherwise.
- `op` in 2: 00 AND, 01 OR, 10 ADD, 11 SUB (A−B).
- `out_valid` out 1: result and flags valid.
- `out_ready` in 1: consumer accepts result.
- `result` out WIDTH: operation result.
- `cout` out 1: final carry. For SUB, 1 means no borrow. 0 for AND/OR.
- `zero` out 1: result == 0.
- `ovf` out 1: signed overflow, ADD/SUB only. 0 for AND/OR.

## Operation
- **FSM states:**
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `out_valid`=1, `in_ready`=0.
- **IDLE → RUN** on `in_valid & in_ready`. On that edge the unit captures `a`, `b` and `op` into shift registers and clears the bit counter.
- **Initial carry** is captured at the same edge: `cin` for ADD, 1 for SUB, 0 for AND/OR.
- **SUB** feeds ~b bits to the slice, so it computes A + ~B + 1.
- **Each RUN cycle:**
  - The slice combines a[0], b[0] and carry.
  - The result bit shifts into `result` from the MSB end; the operand registers shift right.
  - Carry is updated and the counter increments.
- **RUN → DONE** on the edge ending the cycle with counter == WIDTH−1.
- **At that edge:**
  - `cout` latches the final carry.
  - `ovf` latches carry-into-MSB XOR carry-out-of-MSB. Carry-into-MSB is held from the previous RUN cycle.
  - `zero` is derived from the final result; it may be combinational on `result`.
- **DONE → IDLE** on `out_ready`. `result` and flags hold their values until the next operation's first RUN edge.
- **No overlap:** the unit does not accept a new operation in the same cycle that it delivers a result.
- **Ignored inputs:** `in_valid` in RUN/DONE has no effect. Input values matter only in the accept cycle.
- **Counter width:** $clog2(WIDTH). There is no wrap beyond WIDTH−1, because the FSM leaves RUN.

## Timing
- **Reset:** `rst` high at an edge forces IDLE, counter 0, `result`=0, `cout`=0, `ovf`=0, `out_valid`=0. This takes priority over every other event, including reset asserted mid-RUN or in DONE; any partial result is discarded.
- **After reset:** `in_ready`=1 in the first cycle after `rst` deasserts. `in_valid` sampled while `rst` is high is ignored.
- **Latency:** accept in cycle 0; RUN occupies cycles 1..WIDTH; `out_valid`=1 from cycle WIDTH+1.
- **Throughput:** with `out_ready` held high, `in_ready` returns in cycle WIDTH+2, giving one operation per WIDTH+2 cycles.
- **Backpressure:** with `out_ready` low, DONE holds indefinitely and outputs stay stable.
- **Combinational paths:** `in_ready` and `out_valid` decode the registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- **`serial_alu_pkg`** holds:
  - the `alu_op_t` enum (AND/OR/ADD/SUB, 2-bit);
  - the `alu_state_t` enum (IDLE/RUN/DONE);
  - the `OP_*` constants.
- **`alu_bit_slice`** is a combinational sub-module.
  - Inputs: a, b, cin, op.
  - Outputs: r, co.
  - It handles b inversion for SUB internally.
- **`serial_alu`** holds the FSM, counter, shift registers, carry register and flag logic.

## Test plan
(All scenarios use WIDTH=8.)
- ADD a=0x7F, b=0x01, cin=0 → `result`=0x80, `cout`=0, `ovf`=1, `zero`=0; `out_valid` rises exactly 9 cycles after accept.
- ADD a=0xFF, b=0x00, cin=1 → 0x00, `cout`=1, `zero`=1, `ovf`=0. Then SUB 0x00−0x01 → 0xFF, `cout`=0, `ovf`=0.
- SUB 0x80−0x01 → 0x7F, `cout`=1, `ovf`=1. Then SUB 0x05−0x05 → 0x00, `zero`=1, `cout`=1.
- AND 0xF0, 0x3C → 0x30; OR 0xF0, 0x3C → 0xFC. `cout`=`ovf`=0 in both; `cin`=1 has no effect on either.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and pulse `in_valid` with new operands → result/flags stable, `in_ready`=0, new operands not captured. Release `out_ready` → `in_ready`=1 the next cycle.
- Reset in the 4th RUN cycle of an ADD → next cycle IDLE, `out_valid`=0, `result`=0, `in_ready`=1. A subsequent ADD 0x12+0x34 → 0x46.
